// File: rtl/usb_fs_pkg.sv
// Shared definitions for the full-speed USB IN endpoint arbitration logic.
package usb_fs_pkg;

    // Largest number of IN endpoints the arbiter can be built for.
    localparam int unsigned USB_FS_MAX_EPS = 16;

    // Width of endpoint index / rotation pointer fields.
    localparam int unsigned USB_FS_IDX_W = 5;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANTED
    } arb_state_e;

    // Advance an endpoint index by one, wrapping at n with an explicit compare so
    // non-power-of-two endpoint counts wrap correctly.
    function automatic logic [USB_FS_IDX_W-1:0] wrap_inc(input logic [USB_FS_IDX_W-1:0] idx,
                                                          input int unsigned n);
        logic [USB_FS_IDX_W-1:0] nxt;
        nxt = idx + 5'd1;
        return (nxt >= 5'(n)) ? 5'd0 : nxt;
    endfunction

endpackage

// File: rtl/usb_fs_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester found when
// scanning from ptr_i upwards with wrap, optionally skipping one index.
module usb_fs_rr_pick
    import usb_fs_pkg::*;
#(
    parameter int unsigned NumEps = 1
) (
    input  logic [NumEps-1:0]       req_i,
    input  logic [USB_FS_IDX_W-1:0] ptr_i,
    input  logic                    excl_en_i,
    input  logic [USB_FS_IDX_W-1:0] excl_idx_i,
    output logic                    found_o,
    output logic [USB_FS_IDX_W-1:0] idx_o
);

    logic [USB_FS_MAX_EPS-1:0] req_ext;
    logic [USB_FS_IDX_W-1:0]   cand;

    assign req_ext = USB_FS_MAX_EPS'(req_i);

    // Scan NumEps positions starting at the pointer; the first hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NumEps; k++) begin
            cand = ptr_i + 5'(k);
            if (cand >= 5'(NumEps)) begin
                cand = cand - 5'(NumEps);
            end
            if (!found_o && req_ext[cand[3:0]] && !(excl_en_i && (cand == excl_idx_i))) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter sharing the IN protocol engine among NUM_IN_EPS endpoints.
// Grants are registered, priority rotates past each releasing owner, and the
// grant is frozen while the owner still requests or the engine is busy.
module usb_fs_in_rr_arb
    import usb_fs_pkg::*;
#(
    parameter int unsigned NUM_IN_EPS = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN_EPS-1:0]     in_ep_req,
    output logic [NUM_IN_EPS-1:0]     in_ep_grant,
    input  logic [NUM_IN_EPS*8-1:0]   in_ep_data,
    output logic [7:0]                arb_in_ep_data,
    input  logic                      pe_busy,
    output logic [USB_FS_IDX_W-1:0]   arb_owner,
    output logic                      arb_owner_valid
);

    arb_state_e                state_q;
    logic [NUM_IN_EPS-1:0]     grant_q;
    logic [USB_FS_IDX_W-1:0]   owner_q;
    logic [USB_FS_IDX_W-1:0]   ptr_q;
    logic                      valid_q;

    logic [USB_FS_MAX_EPS-1:0] req_ext;
    logic                      hold;
    logic [USB_FS_IDX_W-1:0]   rel_ptr;
    logic [USB_FS_IDX_W-1:0]   pick_ptr;
    logic                      pick_excl_en;
    logic                      pick_found;
    logic [USB_FS_IDX_W-1:0]   pick_idx;
    logic [NUM_IN_EPS-1:0]     pick_onehot;

    assign req_ext = USB_FS_MAX_EPS'(in_ep_req);
    assign hold    = req_ext[owner_q[3:0]] | pe_busy;
    assign rel_ptr = wrap_inc(owner_q, NUM_IN_EPS);

    // On release the pick already uses the advanced pointer and skips the old owner,
    // so a waiting requester takes over on the same edge.
    always_comb begin
        pick_excl_en = (state_q == ARB_GRANTED);
        pick_ptr     = (state_q == ARB_GRANTED) ? rel_ptr : ptr_q;
    end

    usb_fs_rr_pick #(
        .NumEps (NUM_IN_EPS)
    ) u_pick (
        .req_i      (in_ep_req),
        .ptr_i      (pick_ptr),
        .excl_en_i  (pick_excl_en),
        .excl_idx_i (owner_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    // One-hot decode of the picked index.
    always_comb begin
        pick_onehot = '0;
        for (int unsigned i = 0; i < NUM_IN_EPS; i++) begin
            pick_onehot[i] = (pick_idx == 5'(i));
        end
    end

    // Arbiter FSM with registered grant, owner and rotation pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_onehot;
                        owner_q <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= ARB_GRANTED;
                    end
                end
                ARB_GRANTED: begin
                    if (!hold) begin
                        ptr_q <= rel_ptr;
                        if (pick_found) begin
                            grant_q <= pick_onehot;
                            owner_q <= pick_idx;
                        end else begin
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Route the owner's data byte to the protocol engine; zero when nobody owns it.
    always_comb begin
        arb_in_ep_data = 8'h00;
        if (valid_q) begin
            for (int unsigned i = 0; i < NUM_IN_EPS; i++) begin
                if (owner_q == 5'(i)) begin
                    arb_in_ep_data = in_ep_data[8*i +: 8];
                end
            end
        end
    end

    assign in_ep_grant     = grant_q;
    assign arb_owner       = owner_q;
    assign arb_owner_valid = valid_q;

endmodule
